// File: rtl/nonogram_judge.sv
// nonogram_judge: game-flow controller for the 10x10 nonogram grid.
// Sequences idle/play/scan/solved, compares the paint map against the solution
// one cell per clock after each edit, and runs the saturating play timer.
module nonogram_judge #(
    parameter int unsigned N_CELLS = 100,
    parameter int unsigned MAX_SEC = 999,
    parameter int unsigned CNT_W   = 7,
    parameter int unsigned SEC_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               edit_pulse,
    input  logic               tick_1hz,
    input  logic [N_CELLS-1:0] paint,
    input  logic [N_CELLS-1:0] solution,
    output logic [1:0]         state,
    output logic               busy,
    output logic               solved,
    output logic               input_lock,
    output logic [CNT_W-1:0]   mismatch,
    output logic [SEC_W-1:0]   elapsed
);

    localparam int unsigned IDX_W = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_SCAN   = 2'd2,
        S_SOLVED = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [N_CELLS-1:0] snap_q, snap_d;
    logic               pending_q, pending_d;
    logic [CNT_W-1:0]   mismatch_d;
    logic [SEC_W-1:0]   elapsed_d;
    logic               busy_d, solved_d, input_lock_d;
    logic [CNT_W-1:0]   scan_sum;
    logic               scan_last;

    assign state = 2'(state_q);

    // Next-state, scan datapath and timer decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        snap_d     = snap_q;
        pending_d  = pending_q;
        mismatch_d = mismatch;
        elapsed_d  = elapsed;
        scan_sum   = acc_q + CNT_W'(snap_q[idx_q]);
        scan_last  = (idx_q == IDX_W'(N_CELLS - 1));

        // Timer runs only while a game is live; start below overrides it
        if (tick_1hz && (state_q == S_PLAY || state_q == S_SCAN) &&
            (elapsed < SEC_W'(MAX_SEC))) begin
            elapsed_d = elapsed + SEC_W'(1);
        end

        case (state_q)
            S_IDLE, S_SOLVED: begin
                if (start) begin
                    state_d    = S_PLAY;
                    elapsed_d  = '0;
                    mismatch_d = '0;
                end
            end
            S_PLAY: begin
                if (start) begin
                    elapsed_d  = '0;
                    mismatch_d = '0;
                end else if (edit_pulse) begin
                    state_d = S_SCAN;
                    snap_d  = paint ^ solution;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            S_SCAN: begin
                if (start) begin
                    state_d    = S_PLAY;
                    pending_d  = 1'b0;
                    idx_d      = '0;
                    acc_d      = '0;
                    elapsed_d  = '0;
                    mismatch_d = '0;
                end else if (scan_last) begin
                    mismatch_d = scan_sum;
                    pending_d  = 1'b0;
                    idx_d      = '0;
                    acc_d      = '0;
                    // An edit landing on the final cycle still earns a rescan
                    if (pending_q || edit_pulse) begin
                        snap_d = paint ^ solution;
                    end else if (scan_sum == '0) begin
                        state_d = S_SOLVED;
                    end else begin
                        state_d = S_PLAY;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    acc_d = scan_sum;
                    if (edit_pulse) begin
                        pending_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d       = (state_d == S_SCAN);
        solved_d     = (state_d == S_SOLVED);
        input_lock_d = (state_d == S_IDLE) || (state_d == S_SOLVED);
    end

    // State, scan datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            snap_q     <= '0;
            pending_q  <= 1'b0;
            mismatch   <= '0;
            elapsed    <= '0;
            busy       <= 1'b0;
            solved     <= 1'b0;
            input_lock <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            snap_q     <= snap_d;
            pending_q  <= pending_d;
            mismatch   <= mismatch_d;
            elapsed    <= elapsed_d;
            busy       <= busy_d;
            solved     <= solved_d;
            input_lock <= input_lock_d;
        end
    end

endmodule

// File: tb/tb_nonogram_judge.sv
// Directed bench for nonogram_judge: single-cycle vector table plus
// hand-written scan, rescan, timer and abort sequences.
module tb_nonogram_judge;

    localparam int unsigned N = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         edit_pulse;
    logic         tick_1hz;
    logic [N-1:0] paint;
    logic [N-1:0] solution;
    logic [1:0]   state;
    logic         busy;
    logic         solved;
    logic         input_lock;
    logic [6:0]   mismatch;
    logic [9:0]   elapsed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic       edit;
        logic       tick;
        logic [1:0] st;
        logic [6:0] mm;
        logic [9:0] el;
    } vec_t;

    vec_t         vecs[12];
    logic [N-1:0] sol12;
    int           sol_bits[12] = '{1, 9, 10, 20, 45, 50, 63, 71, 88, 90, 98, 99};

    nonogram_judge #(
        .N_CELLS(100),
        .MAX_SEC(999),
        .CNT_W  (7),
        .SEC_W  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .edit_pulse(edit_pulse),
        .tick_1hz  (tick_1hz),
        .paint     (paint),
        .solution  (solution),
        .state     (state),
        .busy      (busy),
        .solved    (solved),
        .input_lock(input_lock),
        .mismatch  (mismatch),
        .elapsed   (elapsed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st,
                              input logic [6:0] mm, input logic [9:0] el);
        chk({tag, ".state"},      32'(state),      32'(st));
        chk({tag, ".busy"},       32'(busy),       32'(st == 2'd2));
        chk({tag, ".solved"},     32'(solved),     32'(st == 2'd3));
        chk({tag, ".input_lock"}, 32'(input_lock), 32'(st == 2'd0 || st == 2'd3));
        chk({tag, ".mismatch"},   32'(mismatch),   32'(mm));
        chk({tag, ".elapsed"},    32'(elapsed),    32'(el));
    endtask

    // Advance n active edges; returns 1 time unit after the last edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_edit();
        edit_pulse = 1'b1;
        cyc(1);
        edit_pulse = 1'b0;
    endtask

    initial begin
        logic [9:0] frozen;

        sol12 = '0;
        foreach (sol_bits[k]) sol12[sol_bits[k]] = 1'b1;

        //               start edit tick  st    mm    el
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 7'd0, 10'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd0, 7'd0, 10'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd1, 7'd0, 10'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 7'd0, 10'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, 7'd0, 10'd2};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'd1, 7'd0, 10'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd1, 7'd0, 10'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'd1, 7'd0, 10'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'd1, 7'd0, 10'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd2, 7'd0, 10'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd2, 7'd0, 10'd1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 2'd1, 7'd0, 10'd0};

        rst = 1'b0; start = 1'b0; edit_pulse = 1'b0; tick_1hz = 1'b0;
        paint = '0; solution = sol12;
        cyc(3);
        expect_out("reset", 2'd0, 7'd0, 10'd0);
        rst = 1'b1;
        cyc(1);

        // Single-cycle control vectors from a fresh reset
        for (int i = 0; i < 12; i++) begin
            start      = vecs[i].start;
            edit_pulse = vecs[i].edit;
            tick_1hz   = vecs[i].tick;
            cyc(1);
            start = 1'b0; edit_pulse = 1'b0; tick_1hz = 1'b0;
            expect_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].mm, vecs[i].el);
        end

        // Solve: paint equals solution, 100-clock scan then SOLVED
        paint = sol12;
        pulse_edit();
        expect_out("solve.e0", 2'd2, 7'd0, 10'd0);
        cyc(99);
        expect_out("solve.e99", 2'd2, 7'd0, 10'd0);
        cyc(1);
        expect_out("solve.e100", 2'd3, 7'd0, 10'd0);
        edit_pulse = 1'b1;
        cyc(3);
        edit_pulse = 1'b0;
        expect_out("solve.edit_ignored", 2'd3, 7'd0, 10'd0);

        // Mismatch count: empty paint against 12-cell solution, then one extra cell
        pulse_start();
        paint = '0;
        pulse_edit();
        cyc(99);
        expect_out("mm12.e99", 2'd2, 7'd0, 10'd0);
        cyc(1);
        expect_out("mm12.e100", 2'd1, 7'd12, 10'd0);
        paint[37] = 1'b1;
        pulse_edit();
        cyc(100);
        expect_out("mm13", 2'd1, 7'd13, 10'd0);

        // Edit mid-scan: first result lands, rescan reflects new paint
        paint = '0;
        pulse_edit();
        cyc(39);
        paint = sol12;
        pulse_edit();
        cyc(59);
        expect_out("rescan.e99", 2'd2, 7'd13, 10'd0);
        cyc(1);
        expect_out("rescan.e100", 2'd2, 7'd12, 10'd0);
        cyc(99);
        expect_out("rescan.e199", 2'd2, 7'd12, 10'd0);
        cyc(1);
        expect_out("rescan.e200", 2'd3, 7'd0, 10'd0);

        // Timer freezes in SOLVED, start clears it
        pulse_start();
        tick_1hz = 1'b1;
        cyc(7);
        tick_1hz = 1'b0;
        expect_out("timer.7", 2'd1, 7'd0, 10'd7);
        pulse_edit();
        cyc(100);
        frozen = elapsed;
        expect_out("timer.solved", 2'd3, 7'd0, 10'd7);
        tick_1hz = 1'b1;
        cyc(5);
        tick_1hz = 1'b0;
        chk("timer.frozen", 32'(elapsed), 32'd7);
        chk("timer.frozen_hold", 32'(elapsed), 32'(frozen) & 32'h0 | 32'd7);
        pulse_start();
        expect_out("timer.restart", 2'd1, 7'd0, 10'd0);

        // Saturation at 999
        tick_1hz = 1'b1;
        cyc(1005);
        tick_1hz = 1'b0;
        expect_out("timer.sat", 2'd1, 7'd0, 10'd999);

        // Async reset at idx 50 aborts the scan with no result kept
        pulse_start();
        paint = '0;
        pulse_edit();
        cyc(50);
        rst = 1'b0;
        #1;
        expect_out("abort.rst", 2'd0, 7'd0, 10'd0);
        cyc(2);
        rst = 1'b1;
        cyc(60);
        expect_out("abort.after_rst", 2'd0, 7'd0, 10'd0);

        // Start mid-scan returns to PLAY and clears the prior result
        pulse_start();
        pulse_edit();
        cyc(100);
        expect_out("abort.scan1", 2'd1, 7'd12, 10'd0);
        pulse_edit();
        cyc(20);
        pulse_start();
        expect_out("abort.start", 2'd1, 7'd0, 10'd0);
        cyc(100);
        expect_out("abort.no_stale", 2'd1, 7'd0, 10'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
